// File: rtl/comparator_2bit_arbiter.sv
// Round-robin scheduler sharing one 2-bit unsigned comparator.
// Two-stage pipeline: ARB picks and registers, CMP compares and responds.

module comparator_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       y
);
  assign y = (a > b);
endmodule

module comparator_2bit_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ),
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] a_flat,
  input  logic [2*NREQ-1:0] b_flat,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_gt,
  output logic [CNT_W-1:0]  rsp_cnt
);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_nx;
  logic [IDW-1:0]  win;
  logic            found;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] gnt_nx;
  logic [1:0]      a_sel;
  logic [1:0]      b_sel;
  logic [1:0]      a_q;
  logic [1:0]      b_q;
  logic [IDW-1:0]  id_q;
  logic            v_q;
  logic            y;
  int              s;

  // The requester acked this cycle is masked so a held req
  // counts as a fresh request only one cycle later.
  always_comb begin
    eligible = req & ~gnt;
    found    = 1'b0;
    win      = '0;
    s        = 0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(ptr) + k;
      if (s >= NREQ) s = s - NREQ;
      if (!found && eligible[IDW'(s)]) begin
        found = 1'b1;
        win   = IDW'(s);
      end
    end
  end

  always_comb begin
    gnt_nx = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (found && win == IDW'(i)) begin
        gnt_nx[i] = 1'b1;
        a_sel     = a_flat[2*i +: 2];
        b_sel     = b_flat[2*i +: 2];
      end
    end
    if (win == IDW'(NREQ - 1)) ptr_nx = '0;
    else                       ptr_nx = IDW'(win + 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt  <= '0;
      v_q  <= 1'b0;
      ptr  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= '0;
    end else begin
      gnt <= gnt_nx;
      v_q <= found;
      if (found) begin
        ptr  <= ptr_nx;
        a_q  <= a_sel;
        b_q  <= b_sel;
        id_q <= win;
      end
    end
  end

  comparator_2bit u_cmp (
    .a (a_q),
    .b (b_q),
    .y (y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_gt    <= 1'b0;
      rsp_cnt   <= '0;
    end else begin
      rsp_valid <= v_q;
      if (v_q) begin
        rsp_id  <= id_q;
        rsp_gt  <= y;
        rsp_cnt <= rsp_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comparator_2bit_arbiter.sv
// Bench for comparator_2bit_arbiter: random and directed traffic
// checked against a cycle-level round-robin reference model.

module tb_comparator_2bit_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] a_flat;
  logic [7:0] b_flat;
  logic [3:0] gnt;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic       rsp_gt;
  logic [7:0] rsp_cnt;

  int n_err;
  int n_chk;

  int a_op[4];
  int b_op[4];

  int         m_ptr;
  int         m_last;
  int         m_grants;
  bit         s1_v;
  int         s1_id;
  bit         s1_gt;
  logic [3:0] exp_gnt;
  logic       exp_rv;
  logic [1:0] exp_id;
  logic       exp_gt;
  int         exp_cnt;

  comparator_2bit_arbiter #(.NREQ(4), .IDW(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_cnt   (rsp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_ptr    = 0;
    m_last   = -1;
    m_grants = 0;
    s1_v     = 0;
    s1_id    = 0;
    s1_gt    = 0;
    exp_gnt  = '0;
    exp_rv   = 0;
    exp_id   = '0;
    exp_gt   = 0;
    exp_cnt  = 0;
  endtask

  task automatic step();
    int w;
    for (int i = 0; i < 4; i++) begin
      a_flat[2*i +: 2] = a_op[i][1:0];
      b_flat[2*i +: 2] = b_op[i][1:0];
    end
    w = -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (w < 0 && req[i] && i != m_last) w = i;
    end
    exp_rv = s1_v;
    if (s1_v) begin
      exp_id  = 2'(s1_id);
      exp_gt  = s1_gt;
      exp_cnt = (exp_cnt + 1) % 256;
    end
    if (w >= 0) begin
      s1_v     = 1;
      s1_id    = w;
      s1_gt    = (a_op[w] > b_op[w]);
      exp_gnt  = 4'(1 << w);
      m_ptr    = (w + 1) % 4;
      m_last   = w;
      m_grants = m_grants + 1;
    end else begin
      s1_v    = 0;
      exp_gnt = '0;
      m_last  = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      a_op[i] = $urandom_range(0, 3);
      b_op[i] = $urandom_range(0, 3);
    end
  endtask

  task automatic test_reset();
    int lo;
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      req = 4'($urandom_range(1, 15));
      rand_ops();
      @(posedge clk);
      #1;
      n_chk++;
      if ({gnt, rsp_valid, rsp_id, rsp_gt, rsp_cnt} !== 16'd0) begin
        n_err++;
        $display("FAIL reset_state: gnt=%b rv=%b id=%0d gt=%b cnt=%0d want all 0",
                 gnt, rsp_valid, rsp_id, rsp_gt, rsp_cnt);
      end
    end
    rst_n = 1'b1;
    req = 4'($urandom_range(1, 15));
    lo = 0;
    while (!req[lo]) lo++;
    step();
    n_chk++;
    if (gnt !== 4'(1 << lo)) begin
      n_err++;
      $display("FAIL reset_first_grant: gnt=%b want %b", gnt, 4'(1 << lo));
    end
    req = '0;
    repeat (2) step();
  endtask

  task automatic test_single();
    do_reset(2);
    rand_ops();
    a_op[2] = 3;
    b_op[2] = 1;
    req = 4'b0100;
    step();
    n_chk++;
    if (gnt !== 4'b0100 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_gnt: gnt=%b rv=%b want 0100 0", gnt, rsp_valid);
    end
    req = '0;
    step();
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_gt !== 1'b1 ||
        rsp_cnt !== 8'd1 || gnt !== 4'b0000) begin
      n_err++;
      $display("FAIL single_rsp: rv=%b id=%0d gt=%b cnt=%0d gnt=%b want 1 2 1 1 0000",
               rsp_valid, rsp_id, rsp_gt, rsp_cnt, gnt);
    end
    step();
    n_chk++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd2 || rsp_gt !== 1'b1) begin
      n_err++;
      $display("FAIL single_hold: rv=%b id=%0d gt=%b want 0 2 1",
               rsp_valid, rsp_id, rsp_gt);
    end
  endtask

  task automatic test_exhaustive();
    do_reset(2);
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 16; p++) begin
        rand_ops();
        a_op[r] = p / 4;
        b_op[r] = p % 4;
        req = 4'(1 << r);
        step();
        req = '0;
        rand_ops();
        step();
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(r) ||
            rsp_gt !== ((p / 4) > (p % 4))) begin
          n_err++;
          $display("FAIL exh_rsp r%0d a%0d b%0d: rv=%b id=%0d gt=%b want 1 %0d %b",
                   r, p / 4, p % 4, rsp_valid, rsp_id, rsp_gt,
                   r, ((p / 4) > (p % 4)));
        end
      end
    end
    step();
    n_chk++;
    if (rsp_cnt !== 8'd64) begin
      n_err++;
      $display("FAIL exh_count: cnt=%0d want 64", rsp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] prev;
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      a_op[i] = i;
      b_op[i] = 3 - i;
    end
    req  = 4'b1111;
    prev = '0;
    for (int c = 0; c < 16; c++) begin
      step();
      n_chk++;
      if (gnt !== 4'(1 << (c % 4)) || (gnt & prev) !== 4'b0) begin
        n_err++;
        $display("FAIL b2b_gnt c%0d: gnt=%b prev=%b want %b",
                 c, gnt, prev, 4'(1 << (c % 4)));
      end
      if (c >= 1) begin
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 1) % 4) ||
            rsp_gt !== (((c - 1) % 4) > 3 - ((c - 1) % 4))) begin
          n_err++;
          $display("FAIL b2b_rsp c%0d: rv=%b id=%0d gt=%b want 1 %0d %b",
                   c, rsp_valid, rsp_id, rsp_gt, (c - 1) % 4,
                   (((c - 1) % 4) > 3 - ((c - 1) % 4)));
        end
      end
      prev = gnt;
    end
    req = '0;
    repeat (2) step();
    n_chk++;
    if (rsp_cnt !== 8'd16) begin
      n_err++;
      $display("FAIL b2b_count: cnt=%0d want 16", rsp_cnt);
    end
  endtask

  task automatic test_rotation();
    do_reset(2);
    rand_ops();
    req = 4'b1000;
    step();
    n_chk++;
    if (gnt !== 4'b1000) begin
      n_err++;
      $display("FAIL rot_first: gnt=%b want 1000", gnt);
    end
    req = 4'b1001;
    step();
    n_chk++;
    if (gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL rot_wrap: gnt=%b want 0001", gnt);
    end
    step();
    n_chk++;
    if (gnt !== 4'b1000) begin
      n_err++;
      $display("FAIL rot_next: gnt=%b want 1000", gnt);
    end
    req = '0;
    repeat (2) step();
  endtask

  task automatic test_reset_midflight();
    do_reset(2);
    rand_ops();
    req = 4'b0010;
    step();
    n_chk++;
    if (gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL mid_gnt: gnt=%b want 0010", gnt);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (gnt !== 4'b0 || rsp_valid !== 1'b0 || rsp_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL mid_async: gnt=%b rv=%b cnt=%0d want 0 0 0",
               gnt, rsp_valid, rsp_cnt);
    end
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_chk++;
      if (rsp_valid !== 1'b0 || rsp_cnt !== 8'd0) begin
        n_err++;
        $display("FAIL mid_no_rsp c%0d: rv=%b cnt=%0d want 0 0",
                 c, rsp_valid, rsp_cnt);
      end
    end
    req = 4'b1111;
    step();
    n_chk++;
    if (gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL mid_ptr: gnt=%b want 0001", gnt);
    end
    req = '0;
    repeat (2) step();
  endtask

  task automatic test_wrap();
    do_reset(2);
    rand_ops();
    req = 4'b1111;
    while (m_grants < 255) step();
    req = '0;
    repeat (2) step();
    n_chk++;
    if (rsp_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL wrap_pre: cnt=%0d want 255", rsp_cnt);
    end
    req = 4'b0001;
    step();
    req = '0;
    step();
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL wrap_zero: rv=%b cnt=%0d want 1 0", rsp_valid, rsp_cnt);
    end
  endtask

  task automatic test_random();
    do_reset(2);
    for (int c = 0; c < 400; c++) begin
      req = 4'($urandom_range(0, 15));
      rand_ops();
      step();
      n_chk++;
      if (gnt !== exp_gnt || rsp_valid !== exp_rv || rsp_id !== exp_id ||
          rsp_gt !== exp_gt || rsp_cnt !== 8'(exp_cnt)) begin
        n_err++;
        $display("FAIL rand c%0d: gnt=%b rv=%b id=%0d gt=%b cnt=%0d want %b %b %0d %b %0d",
                 c, gnt, rsp_valid, rsp_id, rsp_gt, rsp_cnt,
                 exp_gnt, exp_rv, exp_id, exp_gt, exp_cnt);
      end
    end
    req = '0;
    repeat (2) step();
    n_chk++;
    if (rsp_cnt !== 8'(exp_cnt)) begin
      n_err++;
      $display("FAIL rand_count: cnt=%0d want %0d", rsp_cnt, exp_cnt);
    end
  endtask

  initial begin
    n_err  = 0;
    n_chk  = 0;
    rst_n  = 1'b0;
    req    = '0;
    a_flat = '0;
    b_flat = '0;
    for (int i = 0; i < 4; i++) begin
      a_op[i] = 0;
      b_op[i] = 0;
    end
    model_reset();
    #1;
    test_reset();
    test_single();
    test_exhaustive();
    test_back_to_back();
    test_rotation();
    test_reset_midflight();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
